mem_bus_responder: RTL
======================

// Module: mem_bus_responder
// PURPOSE
//  Memory-side responder for the multicycle controller's memRead/memWrite requests.
//  Captures each request, waits a programmable number of cycles, then completes a
//  single-word RAM or memory-mapped-I/O access.
//  Returns read data with a one-cycle rsp_valid pulse.
//  Sits between the datapath address/data buses and on-chip RAM, LEDs and switches.
// PARAMETERS
//  WIDTH        16       data and address width (bits)
//  RAM_AW       10       RAM address bits; depth = 2**RAM_AW words
//  WAIT_STATES  1        extra cycles between accept and response (0..15)
//  IO_BASE      16'hFF00 first MMIO address; addr >= IO_BASE decodes to I/O, not RAM
// PORTS
//  clk        in   1      single clock, rising edge
//  reset      in   1      synchronous, active-high
//  memRead    in   1      read request from controller
//  memWrite   in   1      write request from controller
//  addr       in   WIDTH  word address, sampled at accept
//  wr_data    in   WIDTH  write data, sampled at accept
//  rd_data    out  WIDTH  read data; valid with rsp_valid, held until next response
//  rsp_valid  out  1      one-cycle completion pulse (reads and writes)
//  busy       out  1      high from the cycle after accept through the RESP cycle
//  err        out  1      sticky; set when memRead and memWrite are both high at accept
//  leds       out  WIDTH  LED register (MMIO IO_BASE+0)
//  switches   in   WIDTH  asynchronous switch inputs (MMIO IO_BASE+1)
// BEHAVIOUR
//  Reset values: rd_data=0, rsp_valid=0, busy=0, err=0, leds=0, cycle counter=0, state=IDLE.
//  RAM contents are not reset.
//  FSM states:
//   IDLE: accepts when memRead|memWrite. Captures addr, wr_data and op.
//    -> WAIT if WAIT_STATES>0, else -> RESP.
//   WAIT: counts WAIT_STATES cycles, then -> RESP. Request inputs are ignored.
//   RESP: performs the access and drives rsp_valid=1 for one cycle. -> IDLE.
//  Latency: accept in cycle N; rsp_valid in cycle N+1+WAIT_STATES.
//   Next accept is possible in cycle N+2+WAIT_STATES.
//  A request still held high in IDLE after a response is a new request.
//   The controller must drop memRead/memWrite before the response returns.
//  Both memRead and memWrite high at accept: treated as a write; err<=1.
//   err stays set until reset.
//  The write commits in the RESP cycle only. Reset in WAIT aborts with no side effect.
//  RAM access: index = addr[RAM_AW-1:0]; higher RAM-region bits are ignored (aliasing).
//   RAM reads are synchronous: address issued in the last WAIT/accept cycle, data
//   registered into rd_data at RESP.
//  MMIO map:
//   +0  LED register, read/write.
//   +1  switches, read-only, passed through a 2-flop synchroniser.
//   +2  free-running cycle counter, read-only; increments every cycle, wraps FFFF->0000.
//   Other MMIO addresses read 0; writes to them or to read-only registers are ignored.
//  A write completion leaves rd_data unchanged.
// STRUCTURE
//  Shared package/header: state encodings (IDLE/WAIT/RESP), MMIO offsets
//   (IO_LED=0, IO_SW=1, IO_CYC=2), default IO_BASE.
//  One sub-module: ram_sync_sp. Single-port, synchronous read, write-enable,
//   parameterised WIDTH/RAM_AW, no reset.
//  Top level holds the FSM, wait counter, capture registers, MMIO decode,
//   synchroniser and cycle counter.
// TESTING
//  1 Reset, then write RAM 0x0010<=0xBEEF, then read 0x0010 (WAIT_STATES=1) ->
//    rd_data=0xBEEF, rsp_valid exactly 2 cycles after accept; busy high 2 cycles.
//  2 WAIT_STATES=0: read 0x0003 -> rsp_valid 1 cycle after accept. WAIT_STATES=3 -> 4 cycles.
//  3 Write 0xFF00<=0x00A5 -> leds=0x00A5 at the RESP edge. Write 0xFF02<=0x1234 ->
//    counter unaffected. Read 0xFF05 -> 0x0000.
//  4 switches=0x0F0F, read 0xFF01 -> 0x0F0F (needs >=2 stable cycles before accept).
//    Read 0xFF02 twice, 5 cycles apart -> difference of 5.
//  5 memRead=memWrite=1 at 0x0020, data 0x5555 -> err=1. Read 0x0020 -> 0x5555.
//    err still 1 after further clean requests.
//  6 Aliasing and abort: write 0x0401<=0x7777 with RAM_AW=10, read 0x0001 -> 0x7777.
//    Reset asserted during WAIT of a write to 0x0002 -> no rsp_valid, RAM[2] unchanged.

Source files
------------

// File: rtl/mem_bus_responder_pkg.sv
// Shared definitions for the memory-side bus responder: FSM states, MMIO
// register offsets and the default I/O window base.
package mem_bus_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int IO_LED = 0;
  localparam int IO_SW  = 1;
  localparam int IO_CYC = 2;

  localparam logic [15:0] IO_BASE_DEFAULT = 16'hFF00;

endpackage

// File: rtl/mem_bus_responder_ram_sync_sp.sv
// Single-port RAM with synchronous read and write enable; contents are never
// reset. Read data appears the cycle after the address is presented.
module ram_sync_sp #(
  parameter int WIDTH  = 16,
  parameter int RAM_AW = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [RAM_AW-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem_q [2**RAM_AW];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
    rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_bus_responder.sv
// Memory-side responder: captures a memRead/memWrite request, waits a fixed
// number of cycles, then completes one RAM or MMIO access with a rsp_valid pulse.
module mem_bus_responder
  import mem_bus_responder_pkg::*;
#(
  parameter int                WIDTH       = 16,
  parameter int                RAM_AW      = 10,
  parameter int                WAIT_STATES = 1,
  parameter logic [WIDTH-1:0]  IO_BASE     = WIDTH'(IO_BASE_DEFAULT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             memRead,
  input  logic             memWrite,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             rsp_valid,
  output logic             busy,
  output logic             err,
  output logic [WIDTH-1:0] leds,
  input  logic [WIDTH-1:0] switches
);

  localparam int              WAIT_INIT = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
  localparam logic [3:0]      WAIT_LAST = 4'(WAIT_INIT);
  localparam logic [WIDTH-1:0] OFF_LED  = WIDTH'(IO_LED);
  localparam logic [WIDTH-1:0] OFF_SW   = WIDTH'(IO_SW);
  localparam logic [WIDTH-1:0] OFF_CYC  = WIDTH'(IO_CYC);

  state_e           state_q, state_d;
  logic [3:0]       wait_cnt_q, wait_cnt_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic             is_wr_q, is_wr_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] leds_q, leds_d;
  logic [WIDTH-1:0] cyc_q, cyc_d;
  logic [WIDTH-1:0] rd_hold_q, rd_hold_d;
  logic [WIDTH-1:0] sw_meta_q, sw_meta_d;
  logic [WIDTH-1:0] sw_sync_q, sw_sync_d;

  logic              ram_we_raw;
  logic              ram_we;
  logic [RAM_AW-1:0] ram_addr;
  logic [WIDTH-1:0]  ram_rdata;
  logic              is_io;
  logic [WIDTH-1:0]  io_off;
  logic [WIDTH-1:0]  mmio_rd;
  logic [WIDTH-1:0]  rd_mux;

  // In IDLE the RAM is fed straight from the bus so a zero-wait read has its
  // data ready in the RESP cycle; afterwards the captured address is used.
  assign ram_addr = (state_q == ST_IDLE) ? addr[RAM_AW-1:0] : addr_q[RAM_AW-1:0];
  assign ram_we   = ram_we_raw & ~reset;

  ram_sync_sp #(
    .WIDTH  (WIDTH),
    .RAM_AW (RAM_AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  assign is_io  = (addr_q >= IO_BASE);
  assign io_off = addr_q - IO_BASE;

  always_comb begin
    mmio_rd = '0;
    if (io_off == OFF_LED) begin
      mmio_rd = leds_q;
    end else if (io_off == OFF_SW) begin
      mmio_rd = sw_sync_q;
    end else if (io_off == OFF_CYC) begin
      mmio_rd = cyc_q;
    end
  end

  assign rd_mux = is_io ? mmio_rd : ram_rdata;

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    is_wr_d     = is_wr_q;
    rsp_valid_d = 1'b0;
    busy_d      = busy_q;
    err_d       = err_q;
    leds_d      = leds_q;
    rd_hold_d   = rd_hold_q;
    cyc_d       = cyc_q + 1'b1;
    sw_meta_d   = switches;
    sw_sync_d   = sw_meta_q;
    ram_we_raw  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (memRead | memWrite) begin
          addr_d  = addr;
          wdata_d = wr_data;
          is_wr_d = memWrite;
          busy_d  = 1'b1;
          if (memRead & memWrite) begin
            err_d = 1'b1;
          end
          if (WAIT_STATES > 0) begin
            state_d    = ST_WAIT;
            wait_cnt_d = WAIT_LAST;
          end else begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (wait_cnt_q == 4'd0) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        if (is_wr_q) begin
          if (!is_io) begin
            ram_we_raw = 1'b1;
          end else if (io_off == OFF_LED) begin
            leds_d = wdata_q;
          end
        end else begin
          rd_hold_d = rd_mux;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      wait_cnt_q  <= '0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      leds_q      <= '0;
      cyc_q       <= '0;
      rd_hold_q   <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      leds_q      <= leds_d;
      cyc_q       <= cyc_d;
      rd_hold_q   <= rd_hold_d;
    end
    addr_q    <= addr_d;
    wdata_q   <= wdata_d;
    is_wr_q   <= is_wr_d;
    sw_meta_q <= sw_meta_d;
    sw_sync_q <= sw_sync_d;
  end

  // Read data is live from the access path during RESP and held afterwards.
  assign rd_data   = (state_q == ST_RESP && !is_wr_q) ? rd_mux : rd_hold_q;
  assign rsp_valid = rsp_valid_q;
  assign busy      = busy_q;
  assign err       = err_q;
  assign leds      = leds_q;

endmodule
